// File: rtl/hc595_pkg.sv
// hc595_pkg: shared definitions for the 74HC595 chain driver.
//   state_t        - driver FSM states
//   half_period()  - clk cycles per SRCLK half-period
//   params_legal() - elaboration-time parameter legality check
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    function automatic int half_period(input int clock_freq, input int srclk_freq);
        if (srclk_freq <= 0) return 0;
        return clock_freq / (2 * srclk_freq);
    endfunction

    function automatic bit params_legal(input int h, input int n_chips);
        return (h >= 1) && (n_chips >= 1);
    endfunction

endpackage

// File: rtl/hc595_tick_gen.sv
// hc595_tick_gen: half-period divider for the 595 chain driver.
//   clk, reset - system clock, async active-high reset
//   enable     - divider runs only while high; held at 0 otherwise
//   tick       - one-cycle pulse every H enabled cycles
module hc595_tick_gen #(
    parameter int H = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = $clog2(H) + 1;
    localparam logic [CW-1:0] LAST = CW'(H - 1);

    logic [CW-1:0] r_cnt;

    // Counter sits at 0 while disabled, so the first tick after the FSM
    // leaves IDLE lands exactly H cycles after capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (!enable || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: serial driver for a cascade of N_CHIPS 74HC595s.
//   clk, reset    - system clock, async active-high reset
//   data_in[W]    - frame to send (captured on accept)
//   load          - request, accepted when load & ready
//   auto_refresh  - idle driver self-loads data_in continuously
//   ready         - idle, able to accept a frame
//   done          - one-cycle pulse as RCLK falls at end of frame
//   SRCLK/RCLK/DIO- 595 shift clock, latch clock, serial data
// All outputs are registered.
import hc595_pkg::*;

module hc595_chain_driver #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int SRCLK_FREQ = 12_500_000,
    parameter int N_CHIPS    = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*N_CHIPS-1:0] data_in,
    input  logic                 load,
    input  logic                 auto_refresh,
    output logic                 ready,
    output logic                 done,
    output logic                 SRCLK,
    output logic                 RCLK,
    output logic                 DIO
);

    localparam int W   = 8 * N_CHIPS;
    localparam int H   = half_period(CLOCK_FREQ, SRCLK_FREQ);
    localparam int BCW = $clog2(W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

    generate
        if (!params_legal(H, N_CHIPS)) begin : g_bad_params
            $error("hc595_chain_driver: illegal parameters (H=%0d, N_CHIPS=%0d)", H, N_CHIPS);
        end
    endgenerate

    state_t         r_state;
    logic [W-1:0]   r_shreg;
    logic [BCW-1:0] r_bitcnt;
    logic           r_phase;   // 0: first half-period, 1: second
    logic           r_srclk;
    logic           r_rclk;
    logic           r_dio;
    logic           r_done;
    logic           r_ready;

    logic           w_tick;
    logic           w_start;
    logic [W-1:0]   w_shreg_next;
    logic           w_first_bit;
    logic           w_next_bit;

    hc595_tick_gen #(.H(H)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (r_state != IDLE),
        .tick   (w_tick)
    );

    assign w_start      = load | auto_refresh;
    assign w_shreg_next = MSB_FIRST ? {r_shreg[W-2:0], 1'b0} : {1'b0, r_shreg[W-1:1]};
    assign w_first_bit  = MSB_FIRST ? data_in[W-1] : data_in[0];
    assign w_next_bit   = MSB_FIRST ? w_shreg_next[W-1] : w_shreg_next[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_phase  <= 1'b0;
            r_srclk  <= 1'b0;
            r_rclk   <= 1'b0;
            r_dio    <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        // DIO gets bit 0 straight from data_in so it is valid
                        // for the whole first half-period.
                        r_shreg  <= data_in;
                        r_dio    <= w_first_bit;
                        r_bitcnt <= '0;
                        r_phase  <= 1'b0;
                        r_srclk  <= 1'b0;
                        r_ready  <= 1'b0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            r_srclk <= 1'b1;
                            r_phase <= 1'b1;
                        end else begin
                            // SRCLK falls together with the DIO update, so DIO
                            // never moves while SRCLK is high.
                            r_srclk <= 1'b0;
                            r_phase <= 1'b0;
                            if (r_bitcnt == LAST_BIT) begin
                                r_state <= LATCH;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                                r_shreg  <= w_shreg_next;
                                r_dio    <= w_next_bit;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            r_rclk  <= 1'b1;
                            r_phase <= 1'b1;
                        end else begin
                            r_rclk  <= 1'b0;
                            r_phase <= 1'b0;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign SRCLK = r_srclk;
    assign RCLK  = r_rclk;
    assign DIO   = r_dio;

endmodule

// File: doc/hc595_chain_driver.md
# hc595_chain_driver

Parametrised serial driver for a cascade of N 74HC595 shift registers, such as segment/select lines for multi-digit displays or LED banks. It accepts a parallel word through a load/ready handshake and shifts it out on DIO/SRCLK at a programmable bit rate. It then pulses RCLK once to latch all chips simultaneously and signals completion. Optional auto-refresh mode re-sends data_in continuously without handshaking.

## Interface
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz
- SRCLK_FREQ, 12_500_000, shift clock frequency in Hz; H = CLOCK_FREQ/(2*SRCLK_FREQ) clk cycles per half-period; H < 1 is an elaboration error
- N_CHIPS, 2, number of cascaded 595s; W = 8*N_CHIPS bits per frame
- MSB_FIRST, 1, 1: data_in[W-1] shifted first; 0: data_in[0] shifted first
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- data_in  in  W  frame to send; the bit shifted last ends up in chip 0 bit QA
- load  in  1  request; accepted on a clk edge where load & ready
- auto_refresh  in  1  when high, an idle driver self-loads data_in as if load were asserted
- ready  out  1  high when idle and able to accept a frame
- done  out  1  one-cycle pulse when RCLK falls at the end of a frame
- SRCLK  out  1  595 shift clock
- RCLK  out  1  595 storage/latch clock
- DIO  out  1  595 serial data

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE: ready=1. On (load | auto_refresh): capture data_in into the shadow shift register, clear the bit counter, go to SHIFT, and drop ready.
- SHIFT: each bit takes two half-periods.
  - First half-period: DIO is set to the current bit and SRCLK=0.
  - Second half-period: SRCLK=1, so the rising edge lands mid-bit with DIO stable for H cycles.
  - After bit W-1 completes, go to LATCH.
- LATCH: one half-period with SRCLK=0 and RCLK=0, then one half-period with RCLK=1. Then RCLK=0, done=1 for one cycle, ready=1, and return to IDLE.
- Shadow register shifts by one per bit. Direction is set by MSB_FIRST. data_in changes after capture have no effect on the frame.
- load while ready=0 is ignored, with no queuing. auto_refresh high with load low still sends frames. Both high counts as one request.
- The half-period divider counts 0..H-1 and runs only outside IDLE. It restarts at 0 on capture.
- Bit counter width is $clog2(W). Divider width is $clog2(H)+1. There is no wrap beyond W-1.
- Reset mid-frame aborts the frame. RCLK never pulses, so the 595 outputs keep the previously latched value.

## Timing
- Reset values: SRCLK=0, RCLK=0, DIO=0, done=0, ready=1, state=IDLE.
- Let cycle 0 be the accepting edge.
  - Cycle 1: ready=0, DIO = bit 0.
  - Bit k: DIO changes at cycle 1+2kH; SRCLK rises at 1+(2k+1)H.
  - SRCLK last falls at 1+2WH.
  - RCLK rises at 1+(2W+1)H.
  - RCLK falls, done=1 and ready=1 at 1+(2W+2)H.
- Frame length is (2W+2)H cycles.
- Back-to-back: a load accepted in the done cycle starts the next frame with no gap. The next DIO update comes one cycle later.
- All outputs are registered, with no combinational path from inputs to outputs.
- DIO only changes while SRCLK=0. RCLK is never high while SRCLK=1.

## Structure
- Package hc595_pkg holds:
  - the state enum (IDLE, SHIFT, LATCH)
  - the half-period computation function
  - the parameter-legality check (H >= 1, N_CHIPS >= 1)
- Sub-module hc595_tick_gen is the half-period divider. It takes clk, reset and enable, and outputs a one-cycle tick every H cycles. The FSM advances only on the tick.
- The top level holds the FSM, shadow shift register, bit counter and output registers.

## Test plan
- N_CHIPS=2, H=2, MSB_FIRST=1, load 16'hA55A: sampled DIO at the 16 SRCLK rises = 1010010101011010. RCLK high cycles 67-68. done at cycle 69, ready=1 at cycle 69.
- Same setup with MSB_FIRST=0, data 16'h0001: first sampled bit 1, remaining 15 bits 0. One RCLK pulse.
- load re-asserted with 16'hFFFF at cycle 10 of a frame: ignored. The frame still shifts the original word, and exactly one done pulse occurs.
- auto_refresh held high, load low, data_in changed from 16'h1234 to 16'h5678 mid-frame: the first frame shifts 16'h1234, the next frame starts on the done cycle and shifts 16'h5678. Frame spacing is exactly 68 cycles.
- reset asserted at cycle 20 of a frame: SRCLK, RCLK, DIO and done go to 0 and ready to 1 immediately. No RCLK pulse. A following load completes normally.
- H=1 (SRCLK_FREQ=CLOCK_FREQ/2): SRCLK toggles every cycle. Frame length is 2W+2 cycles.
